// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage RV32I pipeline.
// This stage owns the PC and the instruction-memory request, and it drives the IF/ID register.
// A one-entry hold buffer keeps an instruction that arrives while the hazard unit stalls.
// Because of the buffer, that instruction is never fetched twice.
module if_stage #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     IF_ID_inst,
    output logic [XLEN-1:0] IF_ID_pc,
    output logic [XLEN-1:0] IF_ID_pc4,
    output logic            IF_ID_valid
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    state_t            state_r;
    logic              req_r;
    logic [XLEN-1:0]   pc_r;
    logic [31:0]       buf_inst_r;
    logic [XLEN-1:0]   buf_pc_r;
    logic [31:0]       ifid_inst_r;
    logic [XLEN-1:0]   ifid_pc_r;
    logic [XLEN-1:0]   ifid_pc4_r;
    logic              ifid_valid_r;

    logic [XLEN-1:0]   pc_plus4_s;
    logic [XLEN-1:0]   buf_pc_plus4_s;
    logic [XLEN-1:0]   redirect_aligned_s;

    // Adders and target alignment. PC+4 wraps modulo 2^XLEN, and no carry flag is produced.
    always_comb begin
        pc_plus4_s         = pc_r + XLEN'(4);
        buf_pc_plus4_s     = buf_pc_r + XLEN'(4);
        redirect_aligned_s = {redirect_pc[XLEN-1:2], 2'b00};
    end

    // One block holds the fetch FSM, the PC, the hold buffer and the IF/ID register.
    // Every cycle, a redirect takes priority over a stall, and a stall takes priority over a normal fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_BOOT;
            req_r        <= 1'b0;
            pc_r         <= XLEN'(RESET_PC);
            buf_inst_r   <= NOP_INST;
            buf_pc_r     <= {XLEN{1'b0}};
            ifid_inst_r  <= NOP_INST;
            ifid_pc_r    <= {XLEN{1'b0}};
            ifid_pc4_r   <= {XLEN{1'b0}};
            ifid_valid_r <= 1'b0;
        end else if (redirect) begin
            // Flush: any data that completes in this cycle is dropped, and the buffer is discarded.
            state_r      <= ST_FETCH;
            req_r        <= 1'b1;
            pc_r         <= redirect_aligned_s;
            ifid_inst_r  <= NOP_INST;
            ifid_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    state_r <= ST_FETCH;
                    req_r   <= 1'b1;
                    if (!stall) begin
                        ifid_inst_r  <= NOP_INST;
                        ifid_valid_r <= 1'b0;
                    end else begin
                        ifid_valid_r <= ifid_valid_r;
                    end
                end
                ST_FETCH: begin
                    if (!stall) begin
                        if (imem_ready) begin
                            ifid_inst_r  <= imem_rdata;
                            ifid_pc_r    <= pc_r;
                            ifid_pc4_r   <= pc_plus4_s;
                            ifid_valid_r <= 1'b1;
                            pc_r         <= pc_plus4_s;
                        end else begin
                            ifid_inst_r  <= NOP_INST;
                            ifid_valid_r <= 1'b0;
                        end
                    end else begin
                        if (imem_ready) begin
                            // The instruction completed while IF/ID is frozen, so it is parked in the buffer.
                            buf_inst_r <= imem_rdata;
                            buf_pc_r   <= pc_r;
                            pc_r       <= pc_plus4_s;
                            state_r    <= ST_HELD;
                            req_r      <= 1'b0;
                        end else begin
                            req_r <= 1'b1;
                        end
                    end
                end
                ST_HELD: begin
                    if (!stall) begin
                        ifid_inst_r  <= buf_inst_r;
                        ifid_pc_r    <= buf_pc_r;
                        ifid_pc4_r   <= buf_pc_plus4_s;
                        ifid_valid_r <= 1'b1;
                        state_r      <= ST_FETCH;
                        req_r        <= 1'b1;
                    end else begin
                        req_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_BOOT;
                    req_r        <= 1'b0;
                    ifid_inst_r  <= NOP_INST;
                    ifid_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign IF_ID_inst  = ifid_inst_r;
    assign IF_ID_pc    = ifid_pc_r;
    assign IF_ID_pc4   = ifid_pc4_r;
    assign IF_ID_valid = ifid_valid_r;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage.
// The instruction memory is a small model that returns 0x00100093 plus the word index.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] IF_ID_inst;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_pc4;
    logic        IF_ID_valid;

    int err_cnt;
    int chk_cnt;

    if_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .IF_ID_inst  (IF_ID_inst),
        .IF_ID_pc    (IF_ID_pc),
        .IF_ID_pc4   (IF_ID_pc4),
        .IF_ID_valid (IF_ID_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: each word holds a distinct instruction, so its value identifies its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0010_0093 + (a >> 2);
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the IF/ID register for a real instruction fetched from address a.
    task automatic chk_ifid(input string tag, input logic [31:0] a);
        chk({tag, ".pc"},    IF_ID_pc,    a);
        chk({tag, ".pc4"},   IF_ID_pc4,   a + 32'd4);
        chk({tag, ".inst"},  IF_ID_inst,  mem_word(a));
        chk({tag, ".valid"}, {31'd0, IF_ID_valid}, 32'd1);
    endtask

    initial begin
        err_cnt     = 0;
        chk_cnt     = 0;
        rst_n       = 1'b0;
        imem_ready  = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        #12;
        chk("rst.req",   {31'd0, imem_req}, 32'd0);
        chk("rst.inst",  IF_ID_inst, 32'h0000_0013);
        chk("rst.pc",    IF_ID_pc, 32'd0);
        chk("rst.pc4",   IF_ID_pc4, 32'd0);
        chk("rst.valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("rst.addr",  imem_addr, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("boot.req0", {31'd0, imem_req}, 32'd0);
        step();
        chk("boot.req1", {31'd0, imem_req}, 32'd1);
        chk("boot.addr", imem_addr, 32'd0);
        chk("boot.valid", {31'd0, IF_ID_valid}, 32'd0);

        // Back-to-back fetches: one instruction per cycle
        for (int i = 0; i < 4; i++) begin
            step();
            chk_ifid("seq", 32'(i * 4));
            chk("seq.addr", imem_addr, 32'(i * 4 + 4));
        end

        // Wait states at 0x10
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("ws.inst",  IF_ID_inst, 32'h0000_0013);
            chk("ws.valid", {31'd0, IF_ID_valid}, 32'd0);
            chk("ws.addr",  imem_addr, 32'h10);
            chk("ws.req",   {31'd0, imem_req}, 32'd1);
        end
        imem_ready = 1'b1;
        step();
        chk_ifid("ws.done", 32'h10);
        step();
        step();
        step();
        chk_ifid("pre.stall", 32'h1C);
        chk("pre.stall.addr", imem_addr, 32'h20);

        // Stall while the fetch of 0x20 completes
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ifid("stall.hold", 32'h1C);
            chk("stall.req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        step();
        chk_ifid("stall.rel", 32'h20);
        chk("stall.rel.addr", imem_addr, 32'h24);
        chk("stall.rel.req", {31'd0, imem_req}, 32'd1);
        step();
        chk_ifid("after.rel", 32'h24);

        // Enter HELD with 0x28 buffered, then redirect while still stalled
        stall = 1'b1;
        step();
        chk("held.req", {31'd0, imem_req}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        step();
        chk("redir.addr",  imem_addr, 32'h100);
        chk("redir.req",   {31'd0, imem_req}, 32'd1);
        chk("redir.valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("redir.inst",  IF_ID_inst, 32'h0000_0013);
        chk("redir.pc",    IF_ID_pc, 32'h24);
        redirect = 1'b0;
        stall    = 1'b0;
        step();
        chk_ifid("redir.tgt", 32'h100);

        // Wrap-around at the top of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        chk("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
        redirect = 1'b0;
        step();
        chk_ifid("wrap", 32'hFFFF_FFFC);
        chk("wrap.pc4", IF_ID_pc4, 32'd0);
        chk("wrap.addr", imem_addr, 32'd0);

        // Asynchronous reset between edges in the middle of a fetch
        imem_ready = 1'b0;
        #2;
        chk("ar.pre.req", {31'd0, imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar.req",   {31'd0, imem_req}, 32'd0);
        chk("ar.valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("ar.addr",  imem_addr, 32'd0);
        step();
        rst_n = 1'b1;
        imem_ready = 1'b1;
        step();
        chk("ar.boot.req", {31'd0, imem_req}, 32'd1);
        step();
        chk_ifid("ar.first", 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    // Watchdog so that the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline.
- Owns the PC register and the instruction-memory request, and drives the IF/ID pipeline register that the ID-stage decoder reads as IF_ID_inst.
- Handles hazard-unit stalls, EX-stage redirects (taken branch, JAL, JALR) and a wait-state instruction memory.
- A one-entry hold buffer keeps an instruction that completes during a stall, so it is not refetched.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0) loaded into IF/ID on flush or empty cycle.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request valid for imem_addr.
- imem_addr  out  XLEN  fetch address; equals PC; bits [1:0] always 0.
- imem_rdata  in  32  instruction word; valid when imem_ready=1.
- imem_ready  in  1  request completes this cycle; sampled only when imem_req=1.
- stall  in  1  hazard unit load-use stall: hold PC and IF/ID.
- redirect  in  1  control transfer resolved in EX: flush and refetch.
- redirect_pc  in  XLEN  target address; bits [1:0] ignored (forced 0).
- IF_ID_inst  out  32  registered instruction to the decoder.
- IF_ID_pc  out  XLEN  registered address of IF_ID_inst.
- IF_ID_pc4  out  XLEN  registered IF_ID_pc+4 (JAL/JALR link value).
- IF_ID_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset is asynchronous and active-low on rst_n; there is one clock.
- Reset values:
  - PC=RESET_PC, state=BOOT, hold buffer empty.
  - IF_ID_inst=NOP_INST, IF_ID_pc=0, IF_ID_pc4=0, IF_ID_valid=0.
  - imem_req=0 while rst_n=0.
- Assertion mid-fetch aborts the fetch immediately and drops imem_req.
- States and outputs:
  - BOOT: imem_req=0. Next cycle goes to FETCH.
  - FETCH: imem_req=1, imem_addr=PC.
  - HELD: imem_req=0. Buffer holds {buf_inst, buf_pc}.
- Priority each cycle: redirect > stall > normal.
- redirect=1, any state, regardless of stall or imem_ready:
  - PC<=redirect_pc with [1:0]=00.
  - IF/ID<=bubble: inst=NOP_INST, valid=0, pc/pc4 hold.
  - Buffer discarded; state<=FETCH.
  - Any imem_rdata completing this cycle is dropped.
- FETCH, stall=0, imem_ready=1:
  - IF/ID<={imem_rdata, PC, PC+4, valid=1}; PC<=PC+4.
  - Back-to-back completions give one instruction per cycle.
- FETCH, stall=0, imem_ready=0: IF/ID<=bubble; PC holds.
- FETCH, stall=1, imem_ready=1:
  - buf_inst<=imem_rdata, buf_pc<=PC; PC<=PC+4; state<=HELD.
  - IF/ID holds.
- FETCH, stall=1, imem_ready=0: PC and IF/ID hold; request stays asserted.
- HELD, stall=1: everything holds.
- HELD, stall=0:
  - IF/ID<={buf_inst, buf_pc, buf_pc+4, valid=1}; state<=FETCH.
  - Fetch of PC resumes in the following cycle.
- BOOT, stall=1: still moves to FETCH; IF/ID holds.
- Arithmetic: PC+4 is modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Latency: an instruction completing at edge n is visible on IF_ID_* after edge n (1 cycle), or 1 cycle after stall release if buffered.
- A new request is issued only in FETCH; addr is stable while imem_req=1 and imem_ready=0, unless redirect fires.

Test Plan:
- Reset and boot: rst_n low then high with imem_ready=1, mem[i]=0x00100093+i -> imem_req=0 one cycle; then IF_ID_pc=0,4,8 on consecutive cycles; IF_ID_valid=1; IF_ID_pc4=IF_ID_pc+4.
- Wait states: imem_ready low 2 cycles at PC=0x10 -> two IF/ID bubbles (inst=0x00000013, valid=0); imem_addr stays 0x10; then inst at 0x10 appears.
- Stall with completion: stall=1 for 3 cycles as fetch of 0x20 completes -> IF/ID unchanged; state HELD; imem_req=0. On release, IF_ID_pc=0x20, then next fetch addr=0x24.
- Redirect over stall: redirect=1, redirect_pc=0x103, stall=1 while in HELD -> next imem_addr=0x100; IF_ID_valid=0; buffered instruction never reaches IF/ID.
- Wrap-around: redirect to 0xFFFFFFFC -> IF_ID_pc=0xFFFFFFFC, IF_ID_pc4=0, next imem_addr=0.
- Async reset mid-fetch: rst_n low between edges while imem_req=1 -> imem_req=0 and IF_ID_valid=0 immediately; PC=RESET_PC.
